// File: rtl/chart_sequencer_pkg.sv
// Shared types and constants for the chart sequencer and its spawn FIFO.
// Lane masks are one bit per arrow lane; rom_data carries the end-of-chart flag above the mask.
package stepmania_pkg;

   localparam int NUM_LANES = 4;
   localparam int END_BIT   = 4;

   typedef logic [NUM_LANES-1:0] lane_mask_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FETCH,
      ST_CAPTURE,
      ST_DONE
   } chart_state_t;

   function automatic logic is_playing(chart_state_t s);
      return (s == ST_WAIT) || (s == ST_FETCH) || (s == ST_CAPTURE);
   endfunction

endpackage

// File: rtl/chart_sequencer_if.sv
// Valid/ready spawn channel from the chart sequencer to the arrow renderer.
interface chart_sequencer_if;
   import stepmania_pkg::*;

   logic       spawn_valid;
   lane_mask_t spawn_lanes;
   logic       spawn_ready;

   modport master (output spawn_valid, spawn_lanes, input spawn_ready);
   modport slave  (input spawn_valid, spawn_lanes, output spawn_ready);

endinterface

// File: rtl/chart_sequencer_spawn_fifo.sv
// Small lane-mask FIFO with a combinational head. A push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module spawn_fifo
   import stepmania_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  lane_mask_t push_data,
   input  logic       pop,
   output lane_mask_t head,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   lane_mask_t       mem_q [DEPTH];
   lane_mask_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/chart_sequencer.sv
// Walks a step chart in ROM at a frame-based tempo and queues non-rest lane masks
// for the arrow renderer through a valid/ready FIFO.
module chart_sequencer
   import stepmania_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 15,
   parameter int ADDR_W          = 8,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              frame_clk,
   input  logic              start,
   input  logic              pause,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [4:0]        rom_data,
   chart_sequencer_if.master spawn,
   output logic [ADDR_W-1:0] step_index,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int TCNT_W = $clog2(FRAMES_PER_STEP);

   chart_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [ADDR_W-1:0] step_index_q, step_index_d;
   logic              overflow_q, overflow_d;
   logic              frame_dly_q, frame_dly_d;

   logic       frame_rise, tick_en, last_tick, last_addr, end_hit;
   logic       restart, fifo_push, fifo_pop, fifo_full, fifo_empty;
   lane_mask_t rom_mask, fifo_head;

   assign frame_rise = frame_clk && !frame_dly_q;
   assign tick_en    = frame_rise && !pause;
   assign last_tick  = (tcnt_q == TCNT_W'(FRAMES_PER_STEP - 1));
   assign last_addr  = (addr_q == '1);
   assign end_hit    = rom_data[END_BIT];
   assign rom_mask   = rom_data[NUM_LANES-1:0];

   // FSM state register
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_WAIT;
         ST_WAIT:          if (tick_en && last_tick) state_d = ST_FETCH;
         ST_FETCH:         state_d = ST_CAPTURE;
         ST_CAPTURE:       state_d = (end_hit || last_addr) ? ST_DONE : ST_WAIT;
         default:          state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      restart   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      fifo_push = (state_q == ST_CAPTURE) && !end_hit && (rom_mask != '0);
      busy      = is_playing(state_q);
      done      = (state_q == ST_DONE);
   end

   // Tempo counter, chart address and sticky status
   always_comb begin
      addr_d       = addr_q;
      tcnt_d       = tcnt_q;
      step_index_d = step_index_q;
      overflow_d   = overflow_q;
      frame_dly_d  = frame_clk;
      if (restart) begin
         addr_d     = '0;
         tcnt_d     = '0;
         overflow_d = 1'b0;
      end
      if ((state_q == ST_WAIT) && tick_en) begin
         tcnt_d = last_tick ? '0 : tcnt_q + TCNT_W'(1);
      end
      if (state_q == ST_CAPTURE) begin
         step_index_d = addr_q;
         // The address holds at the last entry so rom_addr never wraps back to 0.
         if (!end_hit && !last_addr) begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q       <= '0;
         tcnt_q       <= '0;
         step_index_q <= '0;
         overflow_q   <= 1'b0;
         frame_dly_q  <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         tcnt_q       <= tcnt_d;
         step_index_q <= step_index_d;
         overflow_q   <= overflow_d;
         frame_dly_q  <= frame_dly_d;
      end
   end

   assign fifo_pop = !fifo_empty && spawn.spawn_ready;

   spawn_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_spawn_fifo (
      .clk       (Clk),
      .rst_n     (reset_n),
      .flush     (restart),
      .push      (fifo_push),
      .push_data (rom_mask),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign spawn.spawn_valid = !fifo_empty;
   assign spawn.spawn_lanes = fifo_head;
   assign rom_addr          = addr_q;
   assign step_index        = step_index_q;
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: tempo, rests, end marker, overflow, pause, restart, async reset.
module tb_chart_sequencer;
   import stepmania_pkg::*;

   localparam int FPS = 2;
   localparam int AW  = 3;
   localparam int FD  = 4;

   logic          Clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic          frame_clk = 1'b0;
   logic          start     = 1'b0;
   logic          pause     = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [AW-1:0] step_index;
   logic [4:0]    rom_data  = '0;
   logic          busy, done, overflow;

   logic [4:0]    rom [8];
   lane_mask_t    got_q [$];
   int            n_checks = 0;
   int            n_fail   = 0;

   chart_sequencer_if spawn_bus();

   chart_sequencer #(
      .FRAMES_PER_STEP (FPS),
      .ADDR_W          (AW),
      .FIFO_DEPTH      (FD)
   ) dut (
      .Clk        (Clk),
      .reset_n    (reset_n),
      .frame_clk  (frame_clk),
      .start      (start),
      .pause      (pause),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .spawn      (spawn_bus),
      .step_index (step_index),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 Clk = ~Clk;

   // Chart ROM with one cycle of read latency
   always @(posedge Clk) rom_data <= rom[rom_addr];

   // Record every accepted spawn; the pop happens at the following rising edge
   always @(negedge Clk) begin
      if (reset_n && spawn_bus.spawn_valid && spawn_bus.spawn_ready) begin
         got_q.push_back(spawn_bus.spawn_lanes);
         $display("spawn accepted lanes=%b", spawn_bus.spawn_lanes);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required end of test before it");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic frame_rises(input int n);
      repeat (n) begin
         frame_clk = 1'b1;
         tick();
         frame_clk = 1'b0;
         tick(4);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tick(3);
      n_checks++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d expected 0", rom_addr); end
      n_checks++; if (spawn_bus.spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", spawn_bus.spawn_valid); end
      n_checks++; if (spawn_bus.spawn_lanes !== 4'b0000) begin n_fail++; $display("FAIL reset_lanes got %b expected 0000", spawn_bus.spawn_lanes); end
      n_checks++; if ({busy, done, overflow} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b expected 000", {busy, done, overflow}); end
      n_checks++; if (step_index !== 3'd0) begin n_fail++; $display("FAIL reset_step_index got %0d expected 0", step_index); end
      reset_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic_chart();
      for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
      rom[0] = 5'b00001; rom[1] = 5'b00000; rom[2] = 5'b01010; rom[3] = 5'b10000;
      spawn_bus.spawn_ready = 1'b1;
      got_q.delete();
      pulse_start();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b expected 1", busy); end
      frame_rises(1);
      n_checks++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL basic_no_fetch_yet rom_addr got %0d expected 0", rom_addr); end
      frame_rises(1);
      n_checks++; if (rom_addr !== 3'd1) begin n_fail++; $display("FAIL basic_first_fetch rom_addr got %0d expected 1", rom_addr); end
      frame_rises(6);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%b busy=%b expected 1 0", done, busy); end
      n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL basic_spawn_count got %0d expected 2", got_q.size()); end
      n_checks++; if (got_q.size() < 2 || got_q[0] !== 4'b0001 || got_q[1] !== 4'b1010) begin n_fail++; $display("FAIL basic_spawn_order got %p expected 0001 then 1010", got_q); end
   endtask

   task automatic test_overflow();
      rom[0] = 5'b00001; rom[1] = 5'b00010; rom[2] = 5'b00100; rom[3] = 5'b01000;
      rom[4] = 5'b01111; rom[5] = 5'b10000;
      spawn_bus.spawn_ready = 1'b0;
      got_q.delete();
      pulse_start();
      frame_rises(12);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b expected 1", overflow); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_done got %b expected 1", done); end
      n_checks++; if (spawn_bus.spawn_valid !== 1'b1 || spawn_bus.spawn_lanes !== 4'b0001) begin n_fail++; $display("FAIL ovf_head got valid=%b lanes=%b expected 1 0001", spawn_bus.spawn_valid, spawn_bus.spawn_lanes); end
      tick(3);
      n_checks++; if (spawn_bus.spawn_lanes !== 4'b0001) begin n_fail++; $display("FAIL ovf_head_stable got %b expected 0001", spawn_bus.spawn_lanes); end
      spawn_bus.spawn_ready = 1'b1;
      tick(6);
      spawn_bus.spawn_ready = 1'b0;
      n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL ovf_held_count got %0d expected 4", got_q.size()); end
      n_checks++; if (got_q.size() < 4 || got_q[0] !== 4'b0001 || got_q[1] !== 4'b0010 || got_q[2] !== 4'b0100 || got_q[3] !== 4'b1000) begin n_fail++; $display("FAIL ovf_order got %p expected 0001 0010 0100 1000", got_q); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
   endtask

   task automatic test_restart();
      pulse_start();
      frame_rises(12);
      n_checks++; if (spawn_bus.spawn_valid !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre got valid=%b ovf=%b expected 1 1", spawn_bus.spawn_valid, overflow); end
      pulse_start();
      n_checks++; if (spawn_bus.spawn_valid !== 1'b0) begin n_fail++; $display("FAIL restart_flush valid got %b expected 0", spawn_bus.spawn_valid); end
      n_checks++; if (overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_status got ovf=%b done=%b busy=%b expected 0 0 1", overflow, done, busy); end
      n_checks++; if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL restart_addr got %0d expected 0", rom_addr); end
      spawn_bus.spawn_ready = 1'b1;
      got_q.delete();
      frame_rises(2);
      n_checks++; if (got_q.size() !== 1 || got_q[0] !== 4'b0001 || rom_addr !== 3'd1) begin n_fail++; $display("FAIL replay_first got n=%0d addr=%0d expected n=1 lanes 0001 addr 1", got_q.size(), rom_addr); end
      pulse_start();
      frame_rises(2);
      n_checks++; if (rom_addr !== 3'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL start_busy_ignored got addr=%0d busy=%b expected 2 1", rom_addr, busy); end
      n_checks++; if (got_q.size() < 2 || got_q[1] !== 4'b0010) begin n_fail++; $display("FAIL start_busy_second got %p expected 0001 0010", got_q); end
      frame_rises(8);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got %b expected 1", done); end
   endtask

   task automatic test_pause();
      rom[0] = 5'b00001; rom[1] = 5'b00010; rom[2] = 5'b00100; rom[3] = 5'b10000;
      spawn_bus.spawn_ready = 1'b1;
      got_q.delete();
      pulse_start();
      frame_rises(3);
      n_checks++; if (rom_addr !== 3'd1 || step_index !== 3'd0) begin n_fail++; $display("FAIL pause_pre got addr=%0d idx=%0d expected 1 0", rom_addr, step_index); end
      pause = 1'b1;
      frame_rises(10);
      n_checks++; if (rom_addr !== 3'd1 || step_index !== 3'd0 || got_q.size() !== 1) begin n_fail++; $display("FAIL pause_frozen got addr=%0d idx=%0d n=%0d expected 1 0 1", rom_addr, step_index, got_q.size()); end
      pause = 1'b0;
      frame_rises(1);
      n_checks++; if (rom_addr !== 3'd2 || step_index !== 3'd1) begin n_fail++; $display("FAIL pause_resume got addr=%0d idx=%0d expected 2 1", rom_addr, step_index); end
      frame_rises(4);
      n_checks++; if (done !== 1'b1 || got_q.size() !== 3) begin n_fail++; $display("FAIL pause_end got done=%b n=%0d expected 1 3", done, got_q.size()); end
   endtask

   task automatic test_no_end();
      for (int i = 0; i < 8; i++) rom[i] = {1'b0, 4'(i + 1)};
      spawn_bus.spawn_ready = 1'b1;
      got_q.delete();
      pulse_start();
      frame_rises(15);
      n_checks++; if (done !== 1'b0 || rom_addr !== 3'd7) begin n_fail++; $display("FAIL noend_pre got done=%b addr=%0d expected 0 7", done, rom_addr); end
      frame_rises(1);
      n_checks++; if (done !== 1'b1 || step_index !== 3'd7) begin n_fail++; $display("FAIL noend_done got done=%b idx=%0d expected 1 7", done, step_index); end
      n_checks++; if (got_q.size() !== 8 || got_q[7] !== 4'b1000) begin n_fail++; $display("FAIL noend_spawns got %p expected 0001..1000", got_q); end
      frame_rises(2);
      n_checks++; if (rom_addr !== 3'd7) begin n_fail++; $display("FAIL noend_no_wrap got %0d expected 7", rom_addr); end
   endtask

   task automatic test_async_reset();
      rom[0] = 5'b00001; rom[1] = 5'b00010; rom[2] = 5'b00100; rom[3] = 5'b10000;
      spawn_bus.spawn_ready = 1'b0;
      pulse_start();
      frame_rises(4);
      n_checks++; if (spawn_bus.spawn_valid !== 1'b1 || step_index !== 3'd1) begin n_fail++; $display("FAIL arst_pre got valid=%b idx=%0d expected 1 1", spawn_bus.spawn_valid, step_index); end
      frame_rises(1);
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++; if (spawn_bus.spawn_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 3'd0 || step_index !== 3'd0) begin n_fail++; $display("FAIL arst_immediate got valid=%b busy=%b addr=%0d idx=%0d expected all 0", spawn_bus.spawn_valid, busy, rom_addr, step_index); end
      tick();
      n_checks++; if ({spawn_bus.spawn_valid, busy, done, overflow} !== 4'b0000 || spawn_bus.spawn_lanes !== 4'b0000) begin n_fail++; $display("FAIL arst_next_clk got %b lanes=%b expected 0000 0000", {spawn_bus.spawn_valid, busy, done, overflow}, spawn_bus.spawn_lanes); end
      reset_n = 1'b1;
      tick(3);
      n_checks++; if (spawn_bus.spawn_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_release got valid=%b busy=%b expected 0 0", spawn_bus.spawn_valid, busy); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rom[i] = 5'b00000;
      spawn_bus.spawn_ready = 1'b0;
      test_reset();
      test_basic_chart();
      test_overflow();
      test_restart();
      test_pause();
      test_no_end();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
